// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings and forwarding helper for the hazard unit
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, JR_WAIT = 2'd2, FLUSH = 2'd3} state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [4:0] REG0 = 5'd0;
  function automatic logic [1:0] fwd_sel(input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we, input logic [4:0] wb_rd,
                                         input logic [4:0] src);
    return (mem_we && mem_rd != REG0 && mem_rd == src) ? FWD_MEM :
           (wb_we && wb_rd != REG0 && wb_rd == src) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline status in, stall/flush/forward controls out
interface hazard_unit_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs, id_uses_rt, id_is_jump, id_is_jr;
  logic ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite, mem_pcsrc;
  logic pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] fwd_a, fwd_b, state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic hazard_err;
  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
           id_uses_rs, id_uses_rt, id_is_jump, id_is_jr,
           ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite, mem_pcsrc,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
           fwd_a, fwd_b, state, stall_cnt, flush_cnt, hazard_err
  );
  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
           id_uses_rs, id_uses_rt, id_is_jump, id_is_jr,
           ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite, mem_pcsrc,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
           fwd_a, fwd_b, state, stall_cnt, flush_cnt, hazard_err
  );
endinterface

// File: rtl/hz_sat_counter.sv
// hz_sat_counter: event counter that sticks at all-ones instead of wrapping
module hz_sat_counter #(parameter int W = 16) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic [W-1:0] q
);
  // count up on inc, hold once saturated
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush sequencing, EX forwarding and hazard monitoring
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int MAX_STALL = 4
) (
  input logic clk,
  input logic reset,
  hazard_unit_if.slave hz
);
  localparam int RW = $clog2(MAX_STALL + 1) > 3 ? $clog2(MAX_STALL + 1) : 3;
  logic lu, jrh, stall;
  logic [RW-1:0] run;
  logic err;
  state_t st;
  // hazard detection; register 0 is hardwired so it never creates a dependency
  always_comb begin
    lu = hz.ex_regwrite && hz.ex_memtoreg && hz.ex_rd != REG0 &&
         ((hz.id_uses_rs && hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && hz.ex_rd == hz.id_rt));
    jrh = hz.id_is_jr && hz.id_rs != REG0 &&
          ((hz.ex_regwrite && hz.ex_rd == hz.id_rs) || (hz.mem_regwrite && hz.mem_rd == hz.id_rs));
    stall = (lu || jrh) && !hz.mem_pcsrc;
  end
  // zero-latency pipeline controls; a taken branch squashes stalls and jumps
  always_comb begin
    hz.pc_en = reset || !stall;
    hz.if_id_en = reset || !stall;
    hz.if_id_flush = reset || hz.mem_pcsrc || (hz.id_is_jump && !stall);
    hz.id_ex_flush = reset || hz.mem_pcsrc || stall;
    hz.ex_mem_flush = reset || hz.mem_pcsrc;
    hz.fwd_a = reset ? FWD_RF : fwd_sel(hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd, hz.ex_rs);
    hz.fwd_b = reset ? FWD_RF : fwd_sel(hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd, hz.ex_rt);
  end
  // debug state tracks which hazard class was seen last cycle
  always_ff @(posedge clk)
    if (reset) st <= RUN;
    else st <= hz.mem_pcsrc ? FLUSH : lu ? LU_STALL : jrh ? JR_WAIT : RUN;
  // watchdog: consecutive-stall run length with a sticky error at MAX_STALL
  always_ff @(posedge clk)
    if (reset) begin
      run <= '0;
      err <= 1'b0;
    end else begin
      run <= !stall ? '0 : (run == RW'(MAX_STALL)) ? run : run + 1'b1;
      err <= err || (stall && run == RW'(MAX_STALL - 1));
    end
  assign hz.state = st;
  assign hz.hazard_err = err;
  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(stall), .q(hz.stall_cnt));
  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(hz.mem_pcsrc), .q(hz.flush_cnt));
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of stalls, flushes, forwarding, watchdog and counters
module tb_hazard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cmp = 0;
  int errs = 0;
  hazard_unit_if #(.CNT_W(3)) hz ();
  hazard_unit #(.CNT_W(3), .MAX_STALL(4)) dut (.clk(clk), .reset(reset), .hz(hz));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    if (obs !== exp) begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs = 0; hz.id_rt = 0; hz.ex_rs = 0; hz.ex_rt = 0; hz.ex_rd = 0;
    hz.mem_rd = 0; hz.wb_rd = 0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
    hz.id_is_jump = 0; hz.id_is_jr = 0; hz.ex_regwrite = 0; hz.ex_memtoreg = 0;
    hz.mem_regwrite = 0; hz.wb_regwrite = 0; hz.mem_pcsrc = 0;
  endtask

  task automatic load_use();
    hz.ex_rd = 2; hz.ex_regwrite = 1; hz.ex_memtoreg = 1; hz.id_rs = 2; hz.id_uses_rs = 1;
  endtask

  initial begin
    idle();
    load_use();
    hz.mem_rd = 7; hz.mem_regwrite = 1; hz.ex_rs = 7;
    #1;
    chk("rst_pc_en", hz.pc_en, 1'b1);
    chk("rst_if_id_en", hz.if_id_en, 1'b1);
    chk("rst_flushes", {hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}, 3'b111);
    chk("rst_fwd_a", hz.fwd_a, 2'b00);
    cyc();
    chk("rst_state", hz.state, 2'd0);
    chk("rst_cnts", {hz.stall_cnt, hz.flush_cnt}, 6'd0);
    chk("rst_err", hz.hazard_err, 1'b0);
    reset = 0;
    idle();
    cyc();
    load_use();
    #1;
    chk("lu_pc_en", hz.pc_en, 1'b0);
    chk("lu_if_id_en", hz.if_id_en, 1'b0);
    chk("lu_flushes", {hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}, 3'b010);
    cyc();
    idle();
    #1;
    chk("lu_state", hz.state, 2'd1);
    chk("lu_stall_cnt", hz.stall_cnt, 3'd1);
    chk("lu_release_pc_en", hz.pc_en, 1'b1);
    load_use();
    hz.ex_rd = 0; hz.id_rs = 0;
    #1;
    chk("lu_r0_pc_en", hz.pc_en, 1'b1);
    cyc();
    idle();
    hz.id_is_jr = 1; hz.id_is_jump = 1; hz.id_rs = 31; hz.id_uses_rs = 1;
    hz.ex_rd = 31; hz.ex_regwrite = 1; hz.ex_memtoreg = 1;
    #1;
    chk("jr1_pc_en", hz.pc_en, 1'b0);
    chk("jr1_if_id_flush", hz.if_id_flush, 1'b0);
    cyc();
    hz.ex_rd = 0; hz.ex_regwrite = 0; hz.ex_memtoreg = 0;
    hz.mem_rd = 31; hz.mem_regwrite = 1;
    #1;
    chk("jr2_pc_en", hz.pc_en, 1'b0);
    chk("jr2_id_ex_flush", hz.id_ex_flush, 1'b1);
    chk("jr2_state", hz.state, 2'd1);
    cyc();
    hz.mem_rd = 0; hz.mem_regwrite = 0;
    #1;
    chk("jr3_state", hz.state, 2'd2);
    chk("jr3_pc_en", hz.pc_en, 1'b1);
    chk("jr3_flushes", {hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}, 3'b100);
    chk("jr3_stall_cnt", hz.stall_cnt, 3'd3);
    cyc();
    idle();
    #1;
    chk("jr_done_state", hz.state, 2'd0);
    chk("jr_err", hz.hazard_err, 1'b0);
    load_use();
    hz.mem_pcsrc = 1;
    #1;
    chk("br_flushes", {hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}, 3'b111);
    chk("br_enables", {hz.pc_en, hz.if_id_en}, 2'b11);
    cyc();
    idle();
    #1;
    chk("br_state", hz.state, 2'd3);
    chk("br_stall_cnt", hz.stall_cnt, 3'd3);
    chk("br_flush_cnt", hz.flush_cnt, 3'd1);
    cyc();
    chk("br_state_after", hz.state, 2'd0);
    hz.mem_rd = 5; hz.mem_regwrite = 1; hz.wb_rd = 5; hz.wb_regwrite = 1;
    hz.ex_rs = 5; hz.ex_rt = 5;
    #1;
    chk("fwd_mem_both", {hz.fwd_a, hz.fwd_b}, 4'b1010);
    hz.mem_regwrite = 0;
    #1;
    chk("fwd_wb_both", {hz.fwd_a, hz.fwd_b}, 4'b0101);
    hz.ex_rt = 6;
    #1;
    chk("fwd_wb_a_rf_b", {hz.fwd_a, hz.fwd_b}, 4'b0100);
    hz.mem_regwrite = 1; hz.mem_rd = 0; hz.wb_rd = 0; hz.ex_rs = 0; hz.ex_rt = 0;
    #1;
    chk("fwd_r0", {hz.fwd_a, hz.fwd_b}, 4'b0000);
    idle();
    reset = 1;
    cyc();
    reset = 0;
    load_use();
    cyc();
    cyc();
    cyc();
    chk("wd_err_3", hz.hazard_err, 1'b0);
    cyc();
    chk("wd_err_4", hz.hazard_err, 1'b1);
    cyc();
    chk("wd_cnt_5", hz.stall_cnt, 3'd5);
    idle();
    cyc();
    chk("wd_err_sticky", hz.hazard_err, 1'b1);
    load_use();
    for (int i = 0; i < 4; i++) cyc();
    chk("sat_stall_cnt", hz.stall_cnt, 3'd7);
    reset = 1;
    #1;
    chk("mid_rst_pc_en", hz.pc_en, 1'b1);
    chk("mid_rst_flushes", {hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}, 3'b111);
    cyc();
    chk("mid_rst_cnts", {hz.stall_cnt, hz.flush_cnt}, 6'd0);
    chk("mid_rst_state", hz.state, 2'd0);
    chk("mid_rst_err", hz.hazard_err, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB).
- Detects data and control hazards and drives the stall and flush enables of the PC and the IF/ID, ID/EX and EX/MEM registers.
- Generates EX-stage forwarding selects.
- Keeps saturating stall/flush performance counters and a sticky watchdog error for runaway stalls.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.
- MAX_STALL, 4, consecutive stall cycles before hazard_err sets.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads that source.
- id_is_jump  in  1  j/jal/jr in ID.
- id_is_jr  in  1  jr in ID; reads rs in ID with no forwarding.
- ex_rs, ex_rt  in  5 each  source registers in EX.
- ex_rd  in  5  destination in EX (after regdst mux).
- ex_regwrite, ex_memtoreg  in  1 each.
- mem_rd  in  5.
- mem_regwrite  in  1.
- wb_rd  in  5.
- wb_regwrite  in  1.
- mem_pcsrc  in  1  branch resolved taken in MEM.
- pc_en  out  1  PC register enable.
- if_id_en  out  1  IF/ID enable (feeds ~stall).
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all-zero controls).
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 10 EX/MEM result, 01 WB result.
- state  out  2  FSM state, for debug.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.
- hazard_err  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values (while reset=1 and the cycle after):
  - Registered outputs: state=RUN, stall_cnt=0, flush_cnt=0, hazard_err=0.
  - Combinational outputs, forced while reset=1: pc_en=1, if_id_en=1, all flushes=1, fwd=00.
- Register 0 never matches any hazard or forward comparison.
- lu (load-use): ex_regwrite & ex_memtoreg & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- jrh (jr hazard): id_is_jr & id_rs!=0 & ((ex_regwrite & ex_rd==id_rs) | (mem_regwrite & mem_rd==id_rs)). WB needs no stall because the register file writes before it reads.
- stall = (lu | jrh) & ~mem_pcsrc.
- Priority, highest first: reset > mem_pcsrc > stall > id_is_jump.
  - mem_pcsrc=1: if_id_flush=id_ex_flush=ex_mem_flush=1; pc_en=1, if_id_en=1. Any stall or jump that cycle is squashed.
  - stall=1: pc_en=0, if_id_en=0, id_ex_flush=1; other flushes 0.
  - id_is_jump & ~stall & ~mem_pcsrc: if_id_flush=1 (drops the wrong-path fetch); pc_en=1.
  - Otherwise all enables are 1 and all flushes are 0.
- Stall and flush outputs are combinational in the same cycle; zero latency.
- Forwarding (combinational, independent of stall):
  - fwd_a=10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs.
  - Else fwd_a=01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs.
  - Else fwd_a=00.
  - fwd_b is the same rule using ex_rt. MEM wins over WB when both match.
- FSM (registered, next state from the current-cycle signals):
  - Encodings: RUN=0, LU_STALL=1, JR_WAIT=2, FLUSH=3.
  - Next = FLUSH if mem_pcsrc; else LU_STALL if lu; else JR_WAIT if jrh; else RUN.
  - FLUSH lasts exactly one cycle unless mem_pcsrc repeats.
- Watchdog:
  - Internal run counter, 3 bits minimum, counts consecutive stall cycles.
  - Clears on any non-stall cycle. Saturates at MAX_STALL.
  - When it reaches MAX_STALL, hazard_err is set and stays set until reset.
  - A legal jr after a load stalls at most 2 cycles, so MAX_STALL=4 never fires on correct code.
- Counters:
  - stall_cnt increments on each stall cycle; flush_cnt increments on each mem_pcsrc cycle.
  - Both saturate at all-ones (no wrap).
  - Reset mid-operation clears both in that cycle.

Decomposition:
- Package hazard_pkg holds:
  - FSM state encodings (RUN, LU_STALL, JR_WAIT, FLUSH).
  - Forwarding encodings FWD_RF=00, FWD_MEM=10, FWD_WB=01.
  - Register-0 constant.
- One natural sub-module: hz_sat_counter (parameter W; ports clk, reset, inc, q). Instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Load-use: lw $2 in EX (ex_rd=2, ex_memtoreg=1), add in ID with id_rs=2 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; state=LU_STALL next cycle; stall_cnt=1.
- jr after lw: id_is_jr, id_rs=31, ex_rd=31, ex_regwrite=1, then mem_rd=31 next cycle -> 2 stall cycles, then if_id_flush=1 for one cycle; hazard_err stays 0.
- Taken branch coinciding with load-use (mem_pcsrc=1, lu=1) -> all three flushes=1, pc_en=1, no stall; stall_cnt unchanged, flush_cnt+1; state=FLUSH.
- Forwarding: mem_rd=5 and wb_rd=5 both writing, ex_rs=5, ex_rt=5 -> fwd_a=fwd_b=10; with rd=0 in both -> 00.
- Watchdog: hold lu=1 for 5 cycles -> hazard_err=1 from the 4th stall cycle; remains 1 after lu drops; clears only on reset.
- Counter saturation with CNT_W=3: 9 stall cycles -> stall_cnt stops at 7; reset asserted mid-stall -> counters=0, state=RUN, outputs forced to reset values that cycle.
